systolic_feed_sequencer: RTL

Control sequencer for one systolic matrix-multiply pass. On `start` it clears the PE accumulators and issues `k_len` consecutive operand-memory reads. It drives the valid bit that enters the row/column skew delay lines, then waits out the array fill/drain latency and pulses `done`. It sits between the host/command logic and the operand memories plus skew buffers feeding the PE grid.

---
 rtl/systolic_feed_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/systolic_feed_sequencer.sv
// Control sequencer for one systolic matrix-multiply pass: clears the PE
// accumulators, streams k_len operand reads, waits out fill/drain, pulses done.
module systolic_feed_sequencer #(
    parameter int DIM    = 2,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              feed_valid,
    output logic              acc_clear,
    output logic              busy,
    output logic              done
);

    // Drain covers 1 memory latency + 2*(DIM-1) skew stages + 1 PE stage.
    localparam int DRAIN_LEN = 2 * DIM;
    localparam int DC_W      = $clog2(DRAIN_LEN + 1);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [K_W-1:0]      k_len_r;
    logic [K_W-1:0]      beat_r;
    logic [DC_W-1:0]     drain_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                issue_s;
    logic                accept_s;
    logic                last_beat_s;
    logic                drain_end_s;

    // Qualifiers shared by the FSM and the datapath counters.
    always_comb begin
        issue_s     = (state_r == ST_FEED) && !hold;
        accept_s    = (state_r == ST_IDLE) && start && (k_len != {K_W{1'b0}});
        last_beat_s = issue_s && (beat_r == (k_len_r - K_W'(1)));
        drain_end_s = (state_r == ST_DRAIN) && (drain_r == DRAIN_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = accept_s ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_next_s = ST_FEED;
            ST_FEED:  state_next_s = last_beat_s ? ST_DRAIN : ST_FEED;
            ST_DRAIN: state_next_s = drain_end_s ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Latched length, beat/drain counters, last issued address, read-latency stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_r    <= {K_W{1'b0}};
            beat_r     <= {K_W{1'b0}};
            drain_r    <= {DC_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            feed_valid <= 1'b0;
        end else begin
            feed_valid <= issue_s;
            if (accept_s) begin
                k_len_r <= k_len;
                beat_r  <= {K_W{1'b0}};
            end else if (issue_s) begin
                beat_r  <= beat_r + K_W'(1);
                addr_r  <= ADDR_W'(beat_r);
            end else begin
                beat_r  <= beat_r;
            end
            if (state_r == ST_DRAIN) begin
                drain_r <= drain_r + DC_W'(1);
            end else begin
                drain_r <= {DC_W{1'b0}};
            end
        end
    end

    // Outputs decoded from state; only the read strobe/address see hold directly.
    always_comb begin
        rd_en     = issue_s;
        rd_addr   = issue_s ? ADDR_W'(beat_r) : addr_r;
        acc_clear = (state_r == ST_CLEAR);
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_DONE);
    end

endmodule
